universal_shift_reg: RTL and testbench

Parametrised universal shift register, WIDTH bits wide. Supports hold, parallel load, shift right, shift left, rotate right, rotate left and synchronous clear. Adds a counted-burst engine: a start/busy/done handshake that runs a captured shift or rotate operation a programmed number of times without the controller stepping it. Sits between the serial-link controllers and the parallel datapath.

---
 rtl/usr_pkg.sv | 28 ++
 rtl/usr_next_mux.sv | 30 +++
 rtl/universal_shift_reg.sv | 94 +++++++++
 tb/tb_universal_shift_reg.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
// Holds the mode encoding, the burst FSM states and the burst-op qualifier.
package usr_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHR  = 3'b010,
      MODE_SHL  = 3'b011,
      MODE_ROR  = 3'b100,
      MODE_ROL  = 3'b101,
      MODE_CLR  = 3'b110,
      MODE_RSVD = 3'b111
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Only the four shift/rotate modes make sense to repeat as a burst.
   function automatic logic is_burst_op(input mode_e m);
      return (m == MODE_SHR) || (m == MODE_SHL) ||
             (m == MODE_ROR) || (m == MODE_ROL);
   endfunction

endpackage

// File: rtl/usr_next_mux.sv
// Combinational next-value selector for the shift register contents.
// Reserved encodings fall back to hold.
module usr_next_mux
   import usr_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  mode_e            mode,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] vec,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] d
);

   always_comb begin
      d = q;
      case (mode)
         MODE_HOLD: d = q;
         MODE_LOAD: d = vec;
         MODE_SHR:  d = {sin_r, q[WIDTH-1:1]};
         MODE_SHL:  d = {q[WIDTH-2:0], sin_l};
         MODE_ROR:  d = {q[0], q[WIDTH-1:1]};
         MODE_ROL:  d = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_CLR:  d = '0;
         default:   d = q;
      endcase
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with a counted-burst engine (start/busy/done).
// Holds the data flops, the IDLE/RUN/DONE FSM and the remaining-step counter.
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [2:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] vec,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   state_e           state, state_nx;
   mode_e            op_q;
   mode_e            mux_mode;
   logic [CNT_W-1:0] rem;
   logic [WIDTH-1:0] d;
   logic             q_en;
   logic             accept;

   usr_next_mux #(.WIDTH(WIDTH)) u_mux (
      .mode  (mux_mode),
      .q     (q),
      .vec   (vec),
      .sin_r (sin_r),
      .sin_l (sin_l),
      .d     (d)
   );

   assign accept = (state == IDLE) && start;

   // In RUN the captured op drives the mux; a start edge never touches q.
   always_comb begin
      state_nx = state;
      mux_mode = mode_e'(mode);
      q_en     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if ((count == '0) || !is_burst_op(mode_e'(mode)))
                  state_nx = DONE;
               else
                  state_nx = RUN;
            end else begin
               q_en = 1'b1;
            end
         end
         RUN: begin
            mux_mode = op_q;
            q_en     = 1'b1;
            if (rem == CNT_W'(1))
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         q     <= '0;
         op_q  <= MODE_HOLD;
         rem   <= '0;
      end else begin
         state <= state_nx;
         if (q_en)
            q <= d;
         if (accept) begin
            op_q <= mode_e'(mode);
            rem  <= count;
         end else if (state == RUN) begin
            rem <= rem - CNT_W'(1);
         end
      end
   end

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=5, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_universal_shift_reg;

   localparam int WIDTH = 5;
   localparam int CNT_W = 8;

   logic             clk;
   logic             clr;
   logic [2:0]       mode;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] vec;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic             busy;
   logic             done;

   int n_cmp  = 0;
   int n_fail = 0;

   universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .clr    (clr),
      .mode   (mode),
      .sin_r  (sin_r),
      .sin_l  (sin_l),
      .vec    (vec),
      .start  (start),
      .count  (count),
      .q      (q),
      .sout_r (sout_r),
      .sout_l (sout_l),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] v);
      mode  = 3'b001;
      vec   = v;
      start = 1'b0;
      step();
      mode  = 3'b000;
   endtask

   task automatic test_reset();
      clr = 1'b0; mode = 3'b000; sin_r = 1'b0; sin_l = 1'b0;
      vec = '0; start = 1'b0; count = '0;
      #2;
      n_cmp++;
      if ({q, busy, done} !== 7'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_state q=%b busy=%b done=%b required 00000/0/0", q, busy, done);
      end
      step();
      clr = 1'b1;
      step();
      n_cmp++;
      if (q !== 5'b00000) begin
         n_fail++;
         $display("[TB] FAIL reset_release_hold q=%b required 00000", q);
      end
   endtask

   task automatic test_load_shift();
      load(5'b10110);
      n_cmp++;
      if (q !== 5'b10110) begin
         n_fail++;
         $display("[TB] FAIL load q=%b required 10110", q);
      end
      mode = 3'b010; sin_r = 1'b1;
      step();
      n_cmp++;
      if (q !== 5'b11011 || sout_r !== 1'b1 || sout_l !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL shr q=%b sout_r=%b sout_l=%b required 11011/1/1", q, sout_r, sout_l);
      end
      load(5'b10110);
      mode = 3'b011; sin_l = 1'b0;
      step();
      n_cmp++;
      if (q !== 5'b01100 || sout_l !== 1'b0 || sout_r !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL shl q=%b sout_l=%b sout_r=%b required 01100/0/0", q, sout_l, sout_r);
      end
      mode = 3'b011; sin_l = 1'b1;
      step();
      n_cmp++;
      if (q !== 5'b11001) begin
         n_fail++;
         $display("[TB] FAIL shl_sin1 q=%b required 11001", q);
      end
      mode = 3'b000;
      step();
      n_cmp++;
      if (q !== 5'b11001) begin
         n_fail++;
         $display("[TB] FAIL hold q=%b required 11001", q);
      end
   endtask

   task automatic test_rotate_clear();
      load(5'b10110);
      mode = 3'b100;
      step();
      n_cmp++;
      if (q !== 5'b01011) begin
         n_fail++;
         $display("[TB] FAIL ror q=%b required 01011", q);
      end
      load(5'b10110);
      mode = 3'b101;
      step();
      n_cmp++;
      if (q !== 5'b01101) begin
         n_fail++;
         $display("[TB] FAIL rol q=%b required 01101", q);
      end
      mode = 3'b110;
      step();
      n_cmp++;
      if (q !== 5'b00000) begin
         n_fail++;
         $display("[TB] FAIL clr_mode q=%b required 00000", q);
      end
      load(5'b10110);
      mode = 3'b111; vec = 5'b01001;
      step();
      n_cmp++;
      if (q !== 5'b10110) begin
         n_fail++;
         $display("[TB] FAIL reserved q=%b required 10110", q);
      end
      mode = 3'b000;
   endtask

   task automatic test_burst();
      logic [WIDTH-1:0] exp_q [3];
      exp_q[0] = 5'b01011; exp_q[1] = 5'b00101; exp_q[2] = 5'b00010;
      load(5'b10110);
      mode = 3'b010; sin_r = 1'b0; count = 8'd3; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b001; vec = 5'b11111;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== 5'b10110) begin
         n_fail++;
         $display("[TB] FAIL burst_start busy=%b done=%b q=%b required 1/0/10110", busy, done, q);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin
            n_fail++;
            $display("[TB] FAIL burst_step%0d q=%b busy=%b done=%b required %b/%b/%b",
                     i, q, busy, done, exp_q[i], (i < 2), (i == 2));
         end
      end
      mode = 3'b000;
      step();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 5'b00010) begin
         n_fail++;
         $display("[TB] FAIL burst_after busy=%b done=%b q=%b required 0/0/00010", busy, done, q);
      end
   endtask

   task automatic test_burst_wrap();
      int busy_cycles = 0;
      int overlap = 0;
      load(5'b10110);
      mode = 3'b101; count = 8'd7; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      for (int i = 0; i < 20 && done !== 1'b1; i++) begin
         if (busy === 1'b1) busy_cycles++;
         step();
         if (busy === 1'b1 && done === 1'b1) overlap++;
      end
      n_cmp++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL wrap_timeout done=%b required 1 within 20 cycles", done);
      end
      n_cmp++;
      if (busy_cycles != 7 || overlap != 0) begin
         n_fail++;
         $display("[TB] FAIL wrap_busy busy_cycles=%0d overlap=%0d required 7/0", busy_cycles, overlap);
      end
      n_cmp++;
      if (q !== 5'b11010) begin
         n_fail++;
         $display("[TB] FAIL wrap_q q=%b required 11010", q);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || q !== 5'b11010) begin
         n_fail++;
         $display("[TB] FAIL wrap_done_pulse done=%b q=%b required 0/11010", done, q);
      end
   endtask

   task automatic test_degenerate();
      load(5'b10110);
      mode = 3'b010; count = 8'd0; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || q !== 5'b10110) begin
         n_fail++;
         $display("[TB] FAIL count0 busy=%b done=%b q=%b required 0/1/10110", busy, done, q);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL count0_after busy=%b done=%b required 0/0", busy, done);
      end
      mode = 3'b001; vec = 5'b00001; count = 8'd5; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || q !== 5'b10110) begin
         n_fail++;
         $display("[TB] FAIL start_load busy=%b done=%b q=%b required 0/1/10110", busy, done, q);
      end
      step();
   endtask

   task automatic test_back_to_back();
      load(5'b10110);
      mode = 3'b011; sin_l = 1'b1; count = 8'd1; start = 1'b1;
      step();
      n_cmp++;
      if (busy !== 1'b1 || q !== 5'b10110) begin
         n_fail++;
         $display("[TB] FAIL b2b_run1 busy=%b q=%b required 1/10110", busy, q);
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || q !== 5'b01101) begin
         n_fail++;
         $display("[TB] FAIL b2b_done1 busy=%b done=%b q=%b required 0/1/01101", busy, done, q);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 5'b01101) begin
         n_fail++;
         $display("[TB] FAIL b2b_idle busy=%b done=%b q=%b required 0/0/01101", busy, done, q);
      end
      step();
      start = 1'b0; mode = 3'b000;
      n_cmp++;
      if (busy !== 1'b1 || q !== 5'b01101) begin
         n_fail++;
         $display("[TB] FAIL b2b_run2 busy=%b q=%b required 1/01101", busy, q);
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || q !== 5'b11011) begin
         n_fail++;
         $display("[TB] FAIL b2b_done2 done=%b q=%b required 1/11011", done, q);
      end
      step();
   endtask

   task automatic test_reset_mid_burst();
      load(5'b10110);
      mode = 3'b010; sin_r = 1'b0; count = 8'd4; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      step();
      n_cmp++;
      if (busy !== 1'b1 || q !== 5'b01011) begin
         n_fail++;
         $display("[TB] FAIL mid_pre busy=%b q=%b required 1/01011", busy, q);
      end
      #1 clr = 1'b0;
      #1;
      n_cmp++;
      if (q !== 5'b00000 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset q=%b busy=%b done=%b required 00000/0/0", q, busy, done);
      end
      #1 clr = 1'b1;
      mode = 3'b001; vec = 5'b10101;
      step();
      mode = 3'b000;
      n_cmp++;
      if (q !== 5'b10101 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL mid_reload q=%b busy=%b done=%b required 10101/0/0", q, busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_load_shift();
      test_rotate_clear();
      test_burst();
      test_burst_wrap();
      test_degenerate();
      test_back_to_back();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
